// File: rtl/cpu_run_monitor.sv
// Run monitor: counts CPU cycles until end-of-program or budget timeout, then streams the
// register file and data memory out on a valid/ready dump channel. Define MON_SIGNATURE_EN for sig_o.
module cpu_run_monitor #(
  parameter int unsigned PC_W       = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned NUM_MEM    = 32,
  parameter int unsigned HALT_PC    = 128,
  parameter int unsigned MAX_CYCLES = 4096,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned RfAw      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int unsigned MemAw     = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [PC_W-1:0]   pc_next_i,
  output logic [RfAw-1:0]   rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic [MemAw-1:0]  dm_addr_o,
  input  logic [7:0]        dm_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_tag_o,
  output logic [15:0]       dump_idx_o,
  output logic [CNT_W-1:0]  cycle_count_o,
  output logic              halted_o,
  output logic              timeout_o,
`ifdef MON_SIGNATURE_EN
  output logic              done_o,
  output logic [31:0]       sig_o
`else
  output logic              done_o
`endif
);

  localparam logic [PC_W-1:0]  HaltPc    = PC_W'(HALT_PC);
  localparam logic [CNT_W-1:0] MaxCnt    = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] MaxCntM1  = CNT_W'(MAX_CYCLES - 1);
  localparam bit               TimeoutEn = (MAX_CYCLES != 0);
  localparam logic [15:0]      LastRf    = 16'(NUM_REGS - 1);
  localparam logic [15:0]      LastMem   = 16'(NUM_MEM - 1);

  typedef enum logic [1:0] {StRun, StDumpRf, StDumpMem, StDone} state_e;

  state_e state_q;
  logic   beat;

  assign beat = dump_valid_o & dump_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= StRun;
      cycle_count_o <= '0;
      halted_o      <= 1'b0;
      timeout_o     <= 1'b0;
      done_o        <= 1'b0;
      dump_valid_o  <= 1'b0;
      dump_tag_o    <= 1'b0;
      dump_idx_o    <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (cycle_count_o != '1) cycle_count_o <= cycle_count_o + 1'b1;
          // End-of-program takes priority over the budget when both fire together.
          if (pc_next_i > HaltPc) begin
            halted_o     <= 1'b1;
            dump_valid_o <= 1'b1;
            dump_tag_o   <= 1'b0;
            dump_idx_o   <= '0;
            state_q      <= StDumpRf;
          end else if (TimeoutEn && cycle_count_o == MaxCntM1) begin
            cycle_count_o <= MaxCnt;
            halted_o      <= 1'b1;
            timeout_o     <= 1'b1;
            dump_valid_o  <= 1'b1;
            dump_tag_o    <= 1'b0;
            dump_idx_o    <= '0;
            state_q       <= StDumpRf;
          end
        end
        StDumpRf: begin
          if (beat) begin
            if (dump_idx_o == LastRf) begin
              dump_tag_o <= 1'b1;
              dump_idx_o <= '0;
              state_q    <= StDumpMem;
            end else begin
              dump_idx_o <= dump_idx_o + 16'd1;
            end
          end
        end
        StDumpMem: begin
          if (beat) begin
            if (dump_idx_o == LastMem) begin
              dump_valid_o <= 1'b0;
              dump_tag_o   <= 1'b0;
              dump_idx_o   <= '0;
              done_o       <= 1'b1;
              state_q      <= StDone;
            end else begin
              dump_idx_o <= dump_idx_o + 16'd1;
            end
          end
        end
        StDone: begin
        end
      endcase
    end
  end

  // Read ports are combinational, so addresses and payload follow the registered index.
  always_comb begin
    rf_addr_o   = '0;
    dm_addr_o   = '0;
    dump_data_o = '0;
    if (state_q == StDumpRf) begin
      rf_addr_o   = dump_idx_o[RfAw-1:0];
      dump_data_o = rf_data_i;
    end else if (state_q == StDumpMem) begin
      dm_addr_o   = dump_idx_o[MemAw-1:0];
      dump_data_o = DATA_W'(dm_data_i);
    end
  end

`ifdef MON_SIGNATURE_EN
  logic [31:0] fold;

  assign fold = 32'(dump_data_o);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sig_o <= '0;
    end else if (beat) begin
      sig_o <= {sig_o[30:0], sig_o[31]} ^ fold;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench for cpu_run_monitor: expected dump beats are queued at halt and popped per beat.
module tb_cpu_run_monitor;

  localparam int unsigned MaxCycles = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_next = '0;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [4:0]  dm_addr;
  logic [7:0]  dm_data;
  logic        dump_valid;
  logic        dump_ready = 1'b1;
  logic [31:0] dump_data;
  logic        dump_tag;
  logic [15:0] dump_idx;
  logic [31:0] cycle_count;
  logic        halted;
  logic        timeout;
  logic        done;
`ifdef MON_SIGNATURE_EN
  logic [31:0] sig;
`endif

  logic [31:0] rf_mem [32];
  logic [7:0]  dm_mem [32];

  typedef struct packed {
    logic        tag;
    logic [15:0] idx;
    logic [31:0] data;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int passed = 0;

  assign rf_data = rf_mem[rf_addr];
  assign dm_data = dm_mem[dm_addr];

  cpu_run_monitor #(
    .MAX_CYCLES(MaxCycles)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pc_next_i    (pc_next),
    .rf_addr_o    (rf_addr),
    .rf_data_i    (rf_data),
    .dm_addr_o    (dm_addr),
    .dm_data_i    (dm_data),
    .dump_valid_o (dump_valid),
    .dump_ready_i (dump_ready),
    .dump_data_o  (dump_data),
    .dump_tag_o   (dump_tag),
    .dump_idx_o   (dump_idx),
    .cycle_count_o(cycle_count),
    .halted_o     (halted),
    .timeout_o    (timeout),
`ifdef MON_SIGNATURE_EN
    .done_o       (done),
    .sig_o        (sig)
`else
    .done_o       (done)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    pc_next    = '0;
    dump_ready = 1'b1;
    step();
    rst = 1'b1;
    sb.delete();
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = $urandom;
      dm_mem[i] = 8'($urandom);
    end
  endtask

  task automatic push_expected();
    for (int i = 0; i < 32; i++) sb.push_back({1'b0, 16'(i), rf_mem[i]});
    for (int i = 0; i < 32; i++) sb.push_back({1'b1, 16'(i), {24'h0, dm_mem[i]}});
  endtask

  // Drives pc = base + inc*n each cycle until the DUT halts (bounded), then queues the dump.
  task automatic run_until_halt(input logic [31:0] base, input logic [31:0] inc, output int n);
    n = 0;
    while (!halted && n < 200) begin
      pc_next = base + inc * 32'(n);
      step();
      n++;
    end
    pc_next = '0;
    push_expected();
  endtask

  task automatic drain(input int stall_at, input int stall_len, input int n_target,
                       output int beats, output int cycles);
    int    stalled;
    beat_t exp;
    beat_t got;
    stalled = 0;
    beats   = 0;
    cycles  = 0;
    while (beats < n_target && cycles < 400) begin
      if (beats == stall_at && stalled < stall_len) begin
        dump_ready = 1'b0;
        step();
        stalled++;
        cycles++;
        exp = (sb.size() > 0) ? sb[0] : '0;
        got = {dump_tag, dump_idx, dump_data};
        checks++;
        if (!dump_valid || sb.size() == 0 || got !== exp)
          $display("FAIL stall_hold: valid=%b beat=%h, required valid=1 beat=%h",
                   dump_valid, got, exp);
        else passed++;
      end else begin
        dump_ready = 1'b1;
        checks++;
        if (!dump_valid || sb.size() == 0) begin
          $display("FAIL beat_valid: valid=%b queued=%0d at beat %0d, required valid=1",
                   dump_valid, sb.size(), beats);
        end else begin
          exp = sb.pop_front();
          got = {dump_tag, dump_idx, dump_data};
          if (got !== exp)
            $display("FAIL beat: got tag/idx/data=%h, required %h", got, exp);
          else passed++;
          beats++;
        end
        step();
        cycles++;
      end
    end
    dump_ready = 1'b1;
  endtask

  task automatic check_done(input string name, input logic [31:0] exp_count,
                            input logic exp_timeout);
    checks++;
    if (dump_valid !== 1'b0 || done !== 1'b1)
      $display("FAIL %s_done: valid=%b done=%b, required valid=0 done=1", name, dump_valid, done);
    else passed++;
    checks++;
    if (halted !== 1'b1 || timeout !== exp_timeout || cycle_count !== exp_count)
      $display("FAIL %s_flags: halted=%b timeout=%b count=%0d, required 1 %b %0d",
               name, halted, timeout, cycle_count, exp_timeout, exp_count);
    else passed++;
    step();
    checks++;
    if (done !== 1'b1 || dump_valid !== 1'b0 || rf_addr !== 5'd0 || dm_addr !== 5'd0 ||
        cycle_count !== exp_count)
      $display("FAIL %s_hold: done=%b valid=%b rf_addr=%0d dm_addr=%0d count=%0d, required 1 0 0 0 %0d",
               name, done, dump_valid, rf_addr, dm_addr, cycle_count, exp_count);
    else passed++;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dump_valid !== 1'b0 || halted !== 1'b0 || timeout !== 1'b0 || done !== 1'b0 ||
        cycle_count !== 32'd0 || rf_addr !== 5'd0 || dm_addr !== 5'd0)
      $display("FAIL reset: valid=%b halted=%b timeout=%b done=%b count=%0d, required all 0",
               dump_valid, halted, timeout, done, cycle_count);
    else passed++;
  endtask

  task automatic test_halt_pc();
    int n, beats, cycles;
    fill_mem();
    rf_mem[5] = 32'hDEADBEEF;
    dm_mem[3] = 8'h7F;
    do_reset();
    run_until_halt(32'd4, 32'd4, n);
    checks++;
    if (n != 33 || cycle_count !== 32'd33 || timeout !== 1'b0)
      $display("FAIL halt_pc: cycles=%0d count=%0d timeout=%b, required 33 33 0",
               n, cycle_count, timeout);
    else passed++;
    checks++;
    if (dump_valid !== 1'b1 || dump_tag !== 1'b0 || dump_idx !== 16'd0)
      $display("FAIL halt_first_beat: valid=%b tag=%b idx=%0d, required 1 0 0",
               dump_valid, dump_tag, dump_idx);
    else passed++;
    drain(-1, 0, 64, beats, cycles);
    checks++;
    if (beats != 64 || cycles != 64)
      $display("FAIL halt_throughput: beats=%0d cycles=%0d, required 64 64", beats, cycles);
    else passed++;
    check_done("halt_pc", 32'd33, 1'b0);
  endtask

  task automatic test_timeout();
    int n, beats, cycles;
    fill_mem();
    do_reset();
    run_until_halt(32'd0, 32'd0, n);
    checks++;
    if (n != 40 || cycle_count !== 32'd40 || timeout !== 1'b1)
      $display("FAIL timeout: cycles=%0d count=%0d timeout=%b, required 40 40 1",
               n, cycle_count, timeout);
    else passed++;
    drain(-1, 0, 64, beats, cycles);
    check_done("timeout", 32'd40, 1'b1);
  endtask

  task automatic test_halt_wins();
    int beats, cycles;
    fill_mem();
    do_reset();
    for (int i = 0; i < 39; i++) step();
    checks++;
    if (halted !== 1'b0 || cycle_count !== 32'd39)
      $display("FAIL pre_budget: halted=%b count=%0d, required 0 39", halted, cycle_count);
    else passed++;
    pc_next = 32'd200;
    step();
    pc_next = '0;
    checks++;
    if (halted !== 1'b1 || timeout !== 1'b0 || cycle_count !== 32'd40)
      $display("FAIL halt_wins: halted=%b timeout=%b count=%0d, required 1 0 40",
               halted, timeout, cycle_count);
    else passed++;
    push_expected();
    drain(-1, 0, 64, beats, cycles);
    check_done("halt_wins", 32'd40, 1'b0);
  endtask

  task automatic test_backpressure();
    int beats, cycles;
    fill_mem();
    do_reset();
    pc_next = 32'd200;
    step();
    pc_next = '0;
    push_expected();
    drain(7, 3, 64, beats, cycles);
    checks++;
    if (beats != 64 || cycles != 67 || sb.size() != 0)
      $display("FAIL backpressure_count: beats=%0d cycles=%0d left=%0d, required 64 67 0",
               beats, cycles, sb.size());
    else passed++;
    check_done("backpressure", 32'd1, 1'b0);
  endtask

  task automatic test_mid_dump_reset();
    int beats, cycles;
    fill_mem();
    do_reset();
    pc_next = 32'd200;
    step();
    pc_next = '0;
    push_expected();
    drain(-1, 0, 42, beats, cycles);
    checks++;
    if (dump_valid !== 1'b1 || dump_tag !== 1'b1 || dump_idx !== 16'd10 || dm_addr !== 5'd10)
      $display("FAIL mid_dump_pos: valid=%b tag=%b idx=%0d dm_addr=%0d, required 1 1 10 10",
               dump_valid, dump_tag, dump_idx, dm_addr);
    else passed++;
    rst = 1'b0;
    step();
    checks++;
    if (dump_valid !== 1'b0 || halted !== 1'b0 || timeout !== 1'b0 || done !== 1'b0 ||
        cycle_count !== 32'd0 || dump_idx !== 16'd0)
      $display("FAIL mid_dump_reset: valid=%b halted=%b timeout=%b done=%b count=%0d idx=%0d, required all 0",
               dump_valid, halted, timeout, done, cycle_count, dump_idx);
    else passed++;
    rst = 1'b1;
    sb.delete();
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (cycle_count !== 32'd6 || halted !== 1'b0 || dump_valid !== 1'b0)
      $display("FAIL restart: count=%0d halted=%b valid=%b, required 6 0 0",
               cycle_count, halted, dump_valid);
    else passed++;
  endtask

`ifdef MON_SIGNATURE_EN
  task automatic test_signature();
    int beats, cycles;
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = '0;
      dm_mem[i] = '0;
    end
    do_reset();
    pc_next = 32'd200;
    step();
    pc_next = '0;
    push_expected();
    drain(-1, 0, 64, beats, cycles);
    checks++;
    if (done !== 1'b1 || sig !== 32'h0)
      $display("FAIL sig_zero: done=%b sig=%h, required 1 00000000", done, sig);
    else passed++;
    rf_mem[0] = 32'd1;
    do_reset();
    pc_next = 32'd200;
    step();
    pc_next = '0;
    push_expected();
    drain(-1, 0, 64, beats, cycles);
    checks++;
    if (done !== 1'b1 || sig !== 32'h8000_0000)
      $display("FAIL sig_one: done=%b sig=%h, required 1 80000000", done, sig);
    else passed++;
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = '0;
      dm_mem[i] = '0;
    end
    test_reset();
    test_halt_pc();
    test_timeout();
    test_halt_wins();
    test_backpressure();
    test_mid_dump_reset();
`ifdef MON_SIGNATURE_EN
    test_signature();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
